// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: decode issue/hazard, ALU and LSU result
// handshakes, and the register-file write port.
interface wb_port_arbiter_if #(
   parameter int W  = 32,
   parameter int AW = 5
);
   // Decode side
   logic          issue_valid_i;
   logic          issue_long_i;
   logic [AW-1:0] issue_rd_i;
   logic [AW-1:0] rs1_addr_i;
   logic [AW-1:0] rs2_addr_i;
   logic          hazard_o;
   // ALU writeback source
   logic          alu_valid_i;
   logic [AW-1:0] alu_rd_i;
   logic [W-1:0]  alu_data_i;
   logic          alu_ready_o;
   // LSU writeback source
   logic          lsu_valid_i;
   logic [AW-1:0] lsu_rd_i;
   logic [W-1:0]  lsu_data_i;
   logic          lsu_ready_o;
   // Register file write port
   logic          write_en_o;
   logic [AW-1:0] write_addr_o;
   logic [W-1:0]  write_data_o;

   // Arbiter side
   modport slave (
      input  issue_valid_i, issue_long_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      output hazard_o, alu_ready_o, lsu_ready_o,
      output write_en_o, write_addr_o, write_data_o
   );

   // Pipeline / stimulus side
   modport master (
      output issue_valid_i, issue_long_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  hazard_o, alu_ready_o, lsu_ready_o,
      input  write_en_o, write_addr_o, write_data_o
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port
// between the ALU and the LSU, with a starvation guard for the ALU and a
// pending-load scoreboard that produces the decode stall flag.
module wb_port_arbiter #(
   parameter int RISCV_WORD_WIDTH = 32,
   parameter int GP_REG_COUNT     = 32,
   parameter int STARVE_LIMIT     = 4
) (
   input logic              clk,
   input logic              rst_n,
   wb_port_arbiter_if.slave bus
);
   localparam int AW = $clog2(GP_REG_COUNT);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic                        both_valid;
   logic                        alu_win;
   logic                        lsu_win;
   logic                        issue_set;
   logic                        hazard;
   logic [3:0]                  starve_q, starve_d;
   logic                        write_en_q, write_en_d;
   logic [AW-1:0]               write_addr_q, write_addr_d;
   logic [RISCV_WORD_WIDTH-1:0] write_data_q, write_data_d;
   logic [GP_REG_COUNT-1:0]     pending_q, pending_d;

   // Grant: LSU has priority unless the ALU has lost STARVE_LIMIT times in a row
   always_comb begin
      both_valid = bus.alu_valid_i & bus.lsu_valid_i;
      alu_win    = bus.alu_valid_i & (~bus.lsu_valid_i | (starve_q == LIMIT));
      lsu_win    = bus.lsu_valid_i & ~alu_win;
   end

   // Stall when a source or a load destination is still awaiting its load data
   always_comb begin
      hazard    = pending_q[bus.rs1_addr_i] | pending_q[bus.rs2_addr_i]
                | (bus.issue_valid_i & bus.issue_long_i & pending_q[bus.issue_rd_i]);
      issue_set = bus.issue_valid_i & bus.issue_long_i & ~hazard
                & (bus.issue_rd_i != '0);
   end

   // Next state: starve counter, write port register and scoreboard bits
   always_comb begin
      starve_d     = starve_q;
      write_en_d   = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      pending_d    = pending_q;

      if (alu_win) begin
         starve_d = 4'd0;
      end else if (both_valid && starve_q != LIMIT) begin
         starve_d = starve_q + 4'd1;
      end

      if (alu_win) begin
         write_en_d   = (bus.alu_rd_i != '0);
         write_addr_d = bus.alu_rd_i;
         write_data_d = bus.alu_data_i;
      end else if (lsu_win) begin
         write_en_d   = (bus.lsu_rd_i != '0);
         write_addr_d = bus.lsu_rd_i;
         write_data_d = bus.lsu_data_i;
      end

      // Clear on the edge the register file stores the data; a new set wins
      for (int i = 1; i < GP_REG_COUNT; i++) begin
         if (write_en_q && write_addr_q == AW'(i)) begin
            pending_d[i] = 1'b0;
         end
         if (issue_set && bus.issue_rd_i == AW'(i)) begin
            pending_d[i] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   // State registers with asynchronous reset dropping anything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q     <= 4'd0;
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         pending_q    <= '0;
      end else begin
         starve_q     <= starve_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         pending_q    <= pending_d;
      end
   end

   assign bus.alu_ready_o  = alu_win;
   assign bus.lsu_ready_o  = lsu_win;
   assign bus.hazard_o     = hazard;
   assign bus.write_en_o   = write_en_q;
   assign bus.write_addr_o = write_addr_q;
   assign bus.write_data_o = write_data_q;
endmodule
